// File: rtl/n64_cmd_tx.sv
// n64_cmd_tx: serializes one command word onto the open-drain N64 bus, MSB first, 4 slots per bit.
// Optional feature macro: N64_TX_ABORT_EN (adds an abort input that kills a frame in flight).
`default_nettype none

module n64_cmd_tx #(
    parameter int TICK_CYCLES = 12,
    parameter int NBITS       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NBITS-1:0] data,
`ifdef N64_TX_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             line_oe
);

    localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int BW = $clog2(NBITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BIT   = 2'd1;
    localparam logic [1:0] S_STOP  = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    localparam logic [CW-1:0] RELOAD   = CW'(TICK_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

    logic [1:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [1:0]       slot, slot_nxt;
    logic [BW-1:0]    bit_idx, bit_nxt;
    logic [NBITS-1:0] shreg, shreg_nxt;
    logic             frame_end;
    logic             oe_nxt, busy_nxt, done_nxt;
    logic             aborting;

`ifdef N64_TX_ABORT_EN
    assign aborting = abort & (state != S_IDLE);
`else
    assign aborting = 1'b0;
`endif

    // State register; outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            slot    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            line_oe <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            slot    <= slot_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            line_oe <= oe_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        slot_nxt  = slot;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        frame_end = 1'b0;
        if (state == S_IDLE) begin
            if (start) begin
                shreg_nxt = data;
                cnt_nxt   = RELOAD;
                slot_nxt  = 2'd0;
                bit_nxt   = '0;
                state_nxt = S_BIT;
            end
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end else begin
            // Slot boundary: reload the timebase and step the frame.
            cnt_nxt = RELOAD;
            case (state)
                S_BIT: begin
                    if (slot == 2'd3) begin
                        slot_nxt = 2'd0;
                        if (bit_idx == LAST_BIT) begin
                            state_nxt = S_STOP;
                        end else begin
                            bit_nxt   = bit_idx + 1'b1;
                            shreg_nxt = shreg << 1;
                        end
                    end else begin
                        slot_nxt = slot + 1'b1;
                    end
                end
                S_STOP:  state_nxt = S_GUARD;
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    frame_end = 1'b1;
                end
            endcase
        end
        if (aborting) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            frame_end = 1'b0;
        end
    end

    always_comb begin
        oe_nxt   = 1'b0;
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = frame_end;
        case (state_nxt)
            S_BIT:   oe_nxt = (slot_nxt == 2'd0) | ((slot_nxt != 2'd3) & ~shreg_nxt[NBITS-1]);
            S_STOP:  oe_nxt = 1'b1;
            default: oe_nxt = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_n64_cmd_tx.sv
// tb_n64_cmd_tx: scoreboard bench for n64_cmd_tx; expected per-cycle {line_oe,busy,done} queued at accept.
`default_nettype none

module tb_n64_cmd_tx;

    localparam int TICK  = 4;
    localparam int NB    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NB-1:0] data;
    logic          abort;
    logic          busy, done, line_oe;

    int n_checks = 0;
    int n_err    = 0;
    logic [2:0] exp_q[$];

    n64_cmd_tx #(.TICK_CYCLES(TICK), .NBITS(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data    (data),
`ifdef N64_TX_ABORT_EN
        .abort   (abort),
`endif
        .busy    (busy),
        .done    (done),
        .line_oe (line_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Expected waveform for one frame, built from the bit encoding.
    task automatic push_frame(input logic [NB-1:0] d);
        for (int i = NB - 1; i >= 0; i--) begin
            int low = d[i] ? TICK : 3 * TICK;
            for (int c = 0; c < 4 * TICK; c++) exp_q.push_back({(c < low), 1'b1, 1'b0});
        end
        for (int c = 0; c < TICK; c++) exp_q.push_back(3'b110);
        for (int c = 0; c < TICK; c++) exp_q.push_back(3'b010);
        exp_q.push_back(3'b001);
    endtask

    // Monitor: one comparison per cycle, idle expected when nothing is queued.
    always @(posedge clk) begin
        logic [2:0] e;
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
        chk("oe_busy_done", {5'b0, line_oe, busy, done}, {5'b0, e});
    end

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One frame; start and data are scribbled mid-frame and must be ignored.
    task automatic send(input logic [NB-1:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(posedge clk);
        push_frame(d);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            data  = NB'($urandom);
            start = (exp_q.size() > 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    // start held high: frames must chain with the accept on the edge ending the done cycle.
    task automatic run_held(input int n);
        @(negedge clk);
        start = 1'b1;
        data  = 8'hA5;
        for (int f = 0; f < n; f++) begin
            @(posedge clk);
            push_frame(8'hA5);
            while (exp_q.size() > 0) begin
                @(negedge clk);
                data = (exp_q.size() > 2) ? NB'($urandom) : 8'hA5;
                if (f == n - 1 && exp_q.size() <= 2) start = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);

        send(8'h01);
        idle(5);
        send(8'hFF);
        idle(3);
        send(8'h00);
        send(8'h3C);
        idle(5);
        run_held(3);
        idle(10);

        // Asynchronous reset in the middle of a 0x01 frame (cycle 50 has line_oe=1).
        @(negedge clk);
        start = 1'b1;
        data  = 8'h01;
        @(posedge clk);
        push_frame(8'h01);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("reset_line_oe", {7'b0, line_oe}, 8'h00);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(10);
        send(8'h01);
        idle(5);

`ifdef N64_TX_ABORT_EN
        // Abort with start also high at cycle 30: abort wins, no done.
        @(negedge clk);
        start = 1'b1;
        data  = 8'h01;
        @(posedge clk);
        push_frame(8'h01);
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);
        // Abort in IDLE is ignored; start on the same edge is accepted.
        abort = 1'b1;
        start = 1'b1;
        data  = 8'hFF;
        @(posedge clk);
        push_frame(8'hFF);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        while (exp_q.size() > 0) @(negedge clk);
        idle(5);
`endif

        idle(20);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
